// File: rtl/fp_wb_arbiter_pkg.sv
// Shared FP writeback types: fflags bit positions and the writeback entry
// carried by per-port holding registers and the output slot.
package fp_wb_arbiter_pkg;

  localparam int FFLAGS_W = 5;
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  // rd is stored at a fixed maximum width; the top zero-extends ADDR_WIDTH into it.
  localparam int FP_WB_RD_W = 8;

  typedef struct packed {
    logic [31:0]           result;
    logic [FP_WB_RD_W-1:0] rd;
    logic                  fp_wr;
    logic [FFLAGS_W-1:0]   fflags;
  } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_arbiter_rr.sv
// Round-robin arbiter: first requester at or after ptr wins, one-hot grant plus index.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     grant_idx,
  output logic                 any
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_PORTS);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP result writeback arbiter: per-port holding registers feeding one registered
// writeback slot. Optional sticky fflags accumulator under FP_WB_STICKY_FFLAGS_EN.
module fp_wb_arbiter
  import fp_wb_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 5,
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_PORTS-1:0]                 in_valid,
  input  logic [NUM_PORTS-1:0][31:0]           in_result,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] in_rd,
  input  logic [NUM_PORTS-1:0]                 in_fp_wr,
  input  logic [NUM_PORTS-1:0][4:0]            in_fflags,
  output logic [NUM_PORTS-1:0]                 stall_o,
  input  logic                                 wb_ready,
  output logic                                 out_valid,
  output logic [31:0]                          out_result,
  output logic [ADDR_WIDTH-1:0]                out_rd,
  output logic                                 out_fp_wr,
  output logic [4:0]                           out_fflags,
  output logic [PTR_W-1:0]                     out_port,
  input  logic                                 fflags_clr,
  output logic [4:0]                           fflags_o
);

  fp_wb_entry_t           hold_q [NUM_PORTS];
  fp_wb_entry_t           live   [NUM_PORTS];
  fp_wb_entry_t           cand   [NUM_PORTS];
  logic [NUM_PORTS-1:0]   hold_full;
  logic [NUM_PORTS-1:0]   cand_valid;
  logic [NUM_PORTS-1:0]   grant;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       rr_next;
  logic                   grant_any;
  logic                   slot_free;
  logic                   grant_en;
  fp_wb_entry_t           out_q;
  logic                   out_valid_q;
  logic [PTR_W-1:0]       out_port_q;
  logic                   unused_ok;

  // A held result always outranks the live inputs of the same port.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      live[i] = '{result: in_result[i], rd: FP_WB_RD_W'(in_rd[i]),
                  fp_wr: in_fp_wr[i], fflags: in_fflags[i]};
      cand[i] = hold_full[i] ? hold_q[i] : live[i];
    end
  end

  assign cand_valid = hold_full | in_valid;
  assign slot_free  = !out_valid_q || wb_ready;
  assign grant_en   = slot_free && grant_any;
  assign rr_next    = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr (
    .req       (cand_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) hold_q[i] <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_port_q  <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      hold_full   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_port_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_en && grant[i]) begin
          hold_full[i] <= 1'b0;
        end else if (in_valid[i] && !hold_full[i]) begin
          hold_full[i] <= 1'b1;
          hold_q[i]    <= live[i];
        end
      end
      if (grant_en) begin
        out_valid_q <= 1'b1;
        out_q       <= cand[grant_idx];
        out_port_q  <= grant_idx;
        rr_ptr      <= rr_next;
      end else if (slot_free) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign stall_o    = hold_full;
  assign out_valid  = out_valid_q;
  assign out_result = out_q.result;
  assign out_rd     = out_q.rd[ADDR_WIDTH-1:0];
  assign out_fp_wr  = out_q.fp_wr;
  assign out_fflags = out_q.fflags;
  assign out_port   = out_port_q;

`ifdef FP_WB_STICKY_FFLAGS_EN
  logic [4:0] sticky_q;
  logic       accept;

  assign accept = out_valid_q && wb_ready;

  // A clear on the same edge as an accepted writeback keeps only the new flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            sticky_q <= '0;
    else if (fflags_clr) sticky_q <= accept ? out_q.fflags : 5'b0;
    else if (accept)     sticky_q <= sticky_q | out_q.fflags;
  end

  assign fflags_o  = sticky_q;
  assign unused_ok = ^out_q.rd;
`else
  assign fflags_o  = '0;
  assign unused_ok = ^{out_q.rd, fflags_clr};
`endif

  // A unit must not present a new result while its holding register is occupied.
  assert property (@(posedge clk) disable iff (!rst) (in_valid & hold_full) == '0);

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: directed vector table, hand sequences for sticky flags
// and mid-operation reset, then random traffic against a behavioural model.
module tb_fp_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [N-1:0]          in_valid;
  logic [N-1:0][31:0]    in_result;
  logic [N-1:0][AW-1:0]  in_rd;
  logic [N-1:0]          in_fp_wr;
  logic [N-1:0][4:0]     in_fflags;
  logic [N-1:0]          stall_o;
  logic                  wb_ready;
  logic                  out_valid;
  logic [31:0]           out_result;
  logic [AW-1:0]         out_rd;
  logic                  out_fp_wr;
  logic [4:0]            out_fflags;
  logic [1:0]            out_port;
  logic                  fflags_clr;
  logic [4:0]            fflags_o;

  int n_cmp = 0;
  int n_bad = 0;

  fp_wb_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_fp_wr   (in_fp_wr),
    .in_fflags  (in_fflags),
    .stall_o    (stall_o),
    .wb_ready   (wb_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_fp_wr  (out_fp_wr),
    .out_fflags (out_fflags),
    .out_port   (out_port),
    .fflags_clr (fflags_clr),
    .fflags_o   (fflags_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    logic [4:0]  ff;
  } ent_t;

  ent_t     m_hold [N];
  bit       m_full [N];
  bit       m_ov;
  ent_t     m_out;
  int       m_port;
  int       m_ptr;
  bit [4:0] m_sticky;

  function automatic void m_reset();
    for (int p = 0; p < N; p++) begin
      m_full[p] = 1'b0;
      m_hold[p] = '0;
    end
    m_ov     = 1'b0;
    m_out    = '0;
    m_port   = 0;
    m_ptr    = 0;
    m_sticky = '0;
  endfunction

  function automatic ent_t live_of(int p);
    ent_t e;
    e.res = in_result[p];
    e.rd  = in_rd[p];
    e.wr  = in_fp_wr[p];
    e.ff  = in_fflags[p];
    return e;
  endfunction

  // Next state from the arbitration rules, using the inputs driven for this edge.
  function automatic void m_step();
    bit accept;
    bit free;
    int win;
    accept = m_ov && wb_ready;
`ifdef FP_WB_STICKY_FFLAGS_EN
    if (fflags_clr)  m_sticky = accept ? m_out.ff : 5'b0;
    else if (accept) m_sticky = m_sticky | m_out.ff;
`endif
    if (flush) begin
      for (int p = 0; p < N; p++) m_full[p] = 1'b0;
      m_ov   = 1'b0;
      m_out  = '0;
      m_port = 0;
      return;
    end
    free = !m_ov || wb_ready;
    win  = -1;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (win < 0 && (m_full[p] || in_valid[p])) win = p;
      end
    end
    if (win >= 0) begin
      m_out  = m_full[win] ? m_hold[win] : live_of(win);
      m_ov   = 1'b1;
      m_port = win;
      m_ptr  = (win + 1) % N;
    end else if (free) begin
      m_ov = 1'b0;
    end
    for (int p = 0; p < N; p++) begin
      if (p == win) m_full[p] = 1'b0;
      else if (in_valid[p] && !m_full[p]) begin
        m_full[p] = 1'b1;
        m_hold[p] = live_of(p);
      end
    end
  endfunction

  task automatic check_model(input string tag);
    logic [N-1:0] exp_stall;
    for (int p = 0; p < N; p++) exp_stall[p] = m_full[p];
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, "_stall"}, 32'(stall_o), 32'(exp_stall));
    chk({tag, "_fflags_o"}, 32'(fflags_o), 32'(m_sticky));
    if (m_ov) begin
      chk({tag, "_result"}, out_result, m_out.res);
      chk({tag, "_rd"}, 32'(out_rd), 32'(m_out.rd));
      chk({tag, "_fp_wr"}, 32'(out_fp_wr), 32'(m_out.wr));
      chk({tag, "_fflags"}, 32'(out_fflags), 32'(m_out.ff));
      chk({tag, "_port"}, 32'(out_port), 32'(m_port));
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_pulses();
    in_valid   = '0;
    flush      = 1'b0;
    fflags_clr = 1'b0;
  endtask

  // One clock with the inputs currently driven; model advances in step with the DUT.
  task automatic cyc(input string tag);
    m_step();
    @(posedge clk);
    #1;
    check_model(tag);
    clear_pulses();
  endtask

  task automatic apply_reset();
    clear_pulses();
    wb_ready = 1'b0;
    rst = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] v;
    logic       wr;
    logic       fl;
    logic       exp_ov;
    int         exp_port;
    logic [3:0] exp_stall;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [3:0] v, logic wr, logic fl, logic eov, int eport, logic [3:0] estall);
    vec_t r;
    r.v = v; r.wr = wr; r.fl = fl; r.exp_ov = eov; r.exp_port = eport; r.exp_stall = estall;
    tbl.push_back(r);
  endfunction

  function automatic logic [31:0] tres(int p);
    return (p == 2) ? 32'h3F80_0000 : 32'h4000_0000 + 32'(p);
  endfunction

  function automatic logic [4:0] trd(int p);
    return (p == 2) ? 5'd7 : 5'(p + 10);
  endfunction

  function automatic logic [4:0] tff(int p);
    logic [4:0] one;
    one = 5'b00001;
    return one << p;
  endfunction

  initial begin
    rst        = 1'b0;
    wb_ready   = 1'b0;
    in_result  = '0;
    in_rd      = '0;
    in_fp_wr   = '0;
    in_fflags  = '0;
    clear_pulses();
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_result", out_result, 32'd0);
    chk("reset_rd", 32'(out_rd), 32'd0);
    chk("reset_port", 32'(out_port), 32'd0);
    chk("reset_fflags_o", 32'(fflags_o), 32'd0);
    rst = 1'b1;

    // Directed table: each row is driven for one edge, expectations are after it.
    add(4'b0100, 1, 0, 1, 2, 4'b0000);  // single port, one-cycle latency
    add(4'b0000, 1, 0, 0, 0, 4'b0000);  // ready with nothing pending drains slot
    add(4'b1000, 1, 0, 1, 3, 4'b0000);  // wraps pointer back to 0
    add(4'b1011, 1, 0, 1, 0, 4'b1010);  // three-way contention
    add(4'b0000, 1, 0, 1, 1, 4'b1000);
    add(4'b0000, 1, 0, 1, 3, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0001, 1, 0, 1, 0, 4'b0000);  // backpressure sequence
    add(4'b0010, 0, 0, 1, 0, 4'b0010);
    add(4'b0000, 0, 0, 1, 0, 4'b0010);
    add(4'b0000, 0, 0, 1, 0, 4'b0010);
    add(4'b0000, 1, 0, 1, 1, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0001, 1, 0, 1, 0, 4'b0000);  // fill all holds, then flush
    add(4'b1111, 0, 0, 1, 0, 4'b1111);
    add(4'b0000, 0, 1, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b0100, 1, 1, 0, 0, 4'b0000);  // flush drops same-cycle inputs
    add(4'b0000, 1, 0, 0, 0, 4'b0000);
    add(4'b1001, 1, 0, 1, 3, 4'b0001);  // pointer survived flush at 1
    add(4'b0000, 1, 0, 1, 0, 4'b0000);

    for (int p = 0; p < N; p++) begin
      in_result[p] = tres(p);
      in_rd[p]     = trd(p);
      in_fp_wr[p]  = p[0];
      in_fflags[p] = tff(p);
    end
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v;
      wb_ready = tbl[i].wr;
      flush    = tbl[i].fl;
      @(posedge clk);
      #1;
      clear_pulses();
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_o), 32'(tbl[i].exp_stall));
      if (tbl[i].exp_ov) begin
        chk($sformatf("tbl%0d_port", i), 32'(out_port), 32'(tbl[i].exp_port));
        chk($sformatf("tbl%0d_result", i), out_result, tres(tbl[i].exp_port));
        chk($sformatf("tbl%0d_rd", i), 32'(out_rd), 32'(trd(tbl[i].exp_port)));
        chk($sformatf("tbl%0d_fp_wr", i), 32'(out_fp_wr), 32'(tbl[i].exp_port % 2));
        chk($sformatf("tbl%0d_fflags", i), 32'(out_fflags), 32'(tff(tbl[i].exp_port)));
      end
      if (tbl[i].fl) chk($sformatf("tbl%0d_flush_result", i), out_result, 32'd0);
    end

    // Sticky flags: 00001 then 10000 accumulate, then clear.
    apply_reset();
    in_fflags[0] = 5'b00001;
    in_fflags[1] = 5'b10000;
    in_valid = 4'b0001; wb_ready = 1'b1; cyc("sticky_a");
    in_valid = 4'b0010; wb_ready = 1'b1; cyc("sticky_b");
    wb_ready = 1'b1; cyc("sticky_c");
`ifdef FP_WB_STICKY_FFLAGS_EN
    chk("sticky_accum", 32'(fflags_o), 32'h11);
`else
    chk("sticky_accum", 32'(fflags_o), 32'h00);
`endif
    fflags_clr = 1'b1; cyc("sticky_clr");
    chk("sticky_cleared", 32'(fflags_o), 32'h00);

    // Reset mid-operation with two ports held and the slot occupied.
    in_valid = 4'b0001; wb_ready = 1'b1; cyc("midrst_a");
    in_valid = 4'b0110; wb_ready = 1'b0; cyc("midrst_b");
    #3;
    rst = 1'b0;
    #1;
    m_reset();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_port", 32'(out_port), 32'd0);
    chk("midrst_fflags_o", 32'(fflags_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_result[3] = 32'hC0A0_0000;
    in_rd[3]     = 5'd19;
    in_valid = 4'b1000; wb_ready = 1'b1; cyc("midrst_c");
    chk("midrst_new_port", 32'(out_port), 32'd3);
    chk("midrst_new_result", out_result, 32'hC0A0_0000);
    wb_ready = 1'b1; cyc("midrst_d");
    chk("midrst_no_stale", 32'(out_valid), 32'd0);

    // Random traffic against the model.
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < N; p++) begin
        in_valid[p]  = ($urandom_range(0, 99) < 40) && !m_full[p];
        in_result[p] = $urandom();
        in_rd[p]     = 5'($urandom_range(0, 31));
        in_fp_wr[p]  = 1'($urandom_range(0, 1));
        in_fflags[p] = 5'($urandom_range(0, 31));
      end
      wb_ready   = ($urandom_range(0, 99) < 60);
      flush      = ($urandom_range(0, 99) < 3);
      fflags_clr = ($urandom_range(0, 99) < 5);
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, count of FP pipeline result ports (fadd, fmul, R4, fdiv/fsqrt).
REQ-002 Parameter ADDR_WIDTH, default 5, destination register index width.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous kill of all buffered and output results.
REQ-006 in_valid  input  NUM_PORTS  per-port result valid (a unit's p_out_signal).
REQ-007 in_result  input  NUM_PORTS x 32  per-port IEEE-754 single result.
REQ-008 in_rd  input  NUM_PORTS x ADDR_WIDTH  per-port destination register.
REQ-009 in_fp_wr  input  NUM_PORTS  per-port write-to-FP-regfile flag (0 = integer regfile).
REQ-010 in_fflags  input  NUM_PORTS x 5  per-port exception flags {NV,DZ,OF,UF,NX}.
REQ-011 stall_o  output  NUM_PORTS  per-port hold request; the unit freezes its pipeline while high.
REQ-012 wb_ready  input  1  downstream writeback accepts out_* this cycle.
REQ-013 out_valid, out_result, out_rd, out_fp_wr, out_fflags  output  1/32/ADDR_WIDTH/1/5  registered writeback slot.
REQ-014 out_port  output  $clog2(NUM_PORTS)  index of the port that produced the out_* result.
REQ-015 fflags_clr  input  1  clear sticky flags (CSR write); fflags_o  output  5  sticky flags (REQ-027).

Function
REQ-016 Each port owns one holding register (hold_full, result, rd, fp_wr, fflags).
REQ-017 stall_o[i] SHALL equal hold_full[i] (registered, no combinational path from in_valid).
REQ-018 Port candidate: holding register if hold_full[i], else the live inputs if in_valid[i]; in_valid[i] while hold_full[i] is a protocol violation (ignored, flagged by assertion).
REQ-019 Slot free = !out_valid || wb_ready.
REQ-020 When the slot is free and at least one candidate exists, exactly one is granted by round-robin starting at rr_ptr; grant is loaded into out_* next edge with out_valid=1.
REQ-021 rr_ptr SHALL advance to (granted index + 1) mod NUM_PORTS after each grant; it is unchanged when no grant occurs.
REQ-022 A granted holding register clears; a non-granted live input loads its holding register the same edge.
REQ-023 Slot not free: out_* hold stable; all live inputs load holding registers.
REQ-024 Latency: uncontended in_valid at edge t, slot free -> out_valid at edge t+1.
REQ-025 wb_ready with no candidate -> out_valid=0 next edge.
REQ-026 flush has priority over all updates: next edge clears all hold_full, out_valid and out_* fields; rr_ptr kept; inputs that cycle dropped.

Reset
REQ-027 On rst low: hold_full=0, out_valid=0, out_result=0, out_rd=0, out_fp_wr=0, out_fflags=0, out_port=0, rr_ptr=0, stall_o=0, fflags_o=0; immediately, independent of clk.
REQ-028 Reset mid-operation discards all buffered results without emitting them.

Configuration
REQ-029 Macro FP_WB_STICKY_FFLAGS_EN: when defined, fflags_o ORs in out_fflags on each accepted writeback (out_valid && wb_ready); fflags_clr zeroes it, clear and accumulate on the same edge -> new flags only.
REQ-030 Without FP_WB_STICKY_FFLAGS_EN, fflags_o is tied to 0, fflags_clr is ignored, and no sticky register exists.

Structure
REQ-031 A shared FP package holds the fflags bit-position constants and a packed fp_wb_entry_t {result, rd, fp_wr, fflags}, used by holding registers and out_*.
REQ-032 One sub-module, rr_arbiter (NUM_PORTS request vector + pointer -> one-hot grant), is natural; the rest is inline.

Verification
REQ-033 Port 2 alone valid, result 0x3F800000, rd 7, wb_ready=1 -> next edge out_valid=1, out_result 0x3F800000, out_rd 7, out_port 2, stall_o=0.
REQ-034 Ports 0,1,3 valid together, rr_ptr=0, wb_ready=1 -> outputs from ports 0,1,3 on three consecutive edges; stall_o[1] and stall_o[3] high until each drains.
REQ-035 wb_ready=0 for 3 cycles with out_valid=1 and port 1 valid -> out_* stable, port 1 held, stall_o[1]=1; wb_ready=1 -> port 1 emitted next edge.
REQ-036 flush with all four holding registers full -> next edge out_valid=0, stall_o=0000, no held result ever emitted.
REQ-037 With FP_WB_STICKY_FFLAGS_EN: writebacks with fflags 00001 then 10000 -> fflags_o=10001; fflags_clr -> 00000; without the macro fflags_o stays 00000.
REQ-038 rst asserted while two ports held and out_valid=1 -> all outputs 0 immediately; after release, first new input emitted at one-cycle latency.
